dm_arbiter_ctrl: RTL

- Owns the single data-memory port and shares it between two requesters: the CPU MEM stage and a word-wide DMA/bridge requester.
- Uses round-robin arbitration.
- Generates byte write enables and replicated write data for sb/sh/sw.
- Checks CPU alignment and range.
- Sequences the 1-cycle synchronous-read latency of the memory, returning sign/zero-extended load data to the CPU and raw words to DMA.

---
 rtl/dm_arbiter_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter_ctrl.sv
// dm_arbiter_ctrl
//   Owns the single synchronous-read data-memory port and shares it between
//   the CPU MEM stage and a word-wide DMA/bridge requester using round-robin
//   arbitration. Builds byte enables and replicated write data for sb/sh/sw,
//   rejects misaligned or out-of-range CPU accesses, and sequences the
//   one-cycle read latency (extended data to the CPU, raw words to DMA).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/size/unsigned   CPU access request and attributes
//   cpu_addr, cpu_wdata        CPU byte address and store data (low bits)
//   cpu_stall                  freeze the pipeline this cycle
//   cpu_rdata                  extended load data, valid when the load completes
//   cpu_err                    single-cycle misaligned/out-of-range pulse
//   dma_req/we/addr/wdata      DMA word request
//   dma_gnt                    DMA request accepted this cycle
//   dma_rvalid, dma_rdata      DMA read response, one cycle after the grant
//   mem_en/we/addr/wdata       memory command port
//   mem_rdata                  memory read data, valid the cycle after a read
module dm_arbiter_ctrl #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU_RSP, DMA_RSP} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;     // 0 = CPU, 1 = DMA
    logic [1:0]  rsp_off_q, rsp_off_d;
    logic [1:0]  rsp_size_q, rsp_size_d;
    logic        rsp_unsigned_q, rsp_unsigned_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    logic cpu_ok, size_ok, cpu_elig, gnt_cpu, gnt_dma;

    // DMA addresses wrap modulo memory size; the byte offset is ignored.
    logic unused_dma_bits;
    assign unused_dma_bits = ^{dma_addr[31:MEM_AW+2], dma_addr[1:0]};

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size,
                                            input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    always_comb begin
        case (cpu_size)
            2'b00:   size_ok = 1'b1;
            2'b01:   size_ok = ~cpu_addr[0];
            2'b10:   size_ok = (cpu_addr[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase
    end

    assign cpu_ok   = size_ok && (cpu_addr[31:MEM_AW+2] == '0);
    // While in CPU_RSP the held request is the load being answered.
    assign cpu_elig = cpu_req && cpu_ok && (state_q != CPU_RSP);
    assign gnt_cpu  = cpu_elig && (!dma_req || last_grant_q);
    assign gnt_dma  = dma_req && !gnt_cpu;

    always_comb begin
        state_d        = IDLE;
        last_grant_d   = last_grant_q;
        rsp_off_d      = rsp_off_q;
        rsp_size_d     = rsp_size_q;
        rsp_unsigned_d = rsp_unsigned_q;
        cpu_rdata_d    = cpu_rdata_q;
        dma_rdata_d    = dma_rdata_q;
        cpu_stall      = 1'b0;
        cpu_err        = 1'b0;
        dma_gnt        = 1'b0;
        dma_rvalid     = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 4'b0000;
        mem_addr       = cpu_addr[MEM_AW+1:2];
        mem_wdata      = store_data(cpu_size, cpu_wdata);
        cpu_rdata      = cpu_rdata_q;
        dma_rdata      = dma_rdata_q;

        if (reset) begin
            // A reset drops any pending response and forces outputs low.
            cpu_rdata = '0;
            dma_rdata = '0;
        end else begin
            if (state_q == CPU_RSP) begin
                cpu_rdata_d = load_extract(mem_rdata, rsp_off_q, rsp_size_q, rsp_unsigned_q);
                cpu_rdata   = cpu_rdata_d;
            end
            if (state_q == DMA_RSP) begin
                dma_rdata_d = mem_rdata;
                dma_rdata   = mem_rdata;
                dma_rvalid  = 1'b1;
            end

            cpu_err = cpu_req && !cpu_ok;

            if (gnt_cpu) begin
                mem_en       = 1'b1;
                mem_we       = cpu_we ? store_be(cpu_size, cpu_addr[1:0]) : 4'b0000;
                last_grant_d = 1'b0;
                if (!cpu_we) begin
                    cpu_stall      = 1'b1;
                    state_d        = CPU_RSP;
                    rsp_off_d      = cpu_addr[1:0];
                    rsp_size_d     = cpu_size;
                    rsp_unsigned_d = cpu_unsigned;
                end
            end else if (gnt_dma) begin
                dma_gnt      = 1'b1;
                mem_en       = 1'b1;
                mem_addr     = dma_addr[MEM_AW+1:2];
                mem_wdata    = dma_wdata;
                mem_we       = {4{dma_we}};
                last_grant_d = 1'b1;
                cpu_stall    = cpu_elig;   // lost arbitration, retry next cycle
                if (!dma_we) begin
                    state_d = DMA_RSP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        rsp_off_q      <= rsp_off_d;
        rsp_size_q     <= rsp_size_d;
        rsp_unsigned_q <= rsp_unsigned_d;
    end

endmodule
